// File: rtl/desloc_seq_if.sv
// -----------------------------------------------------------------------------
// desloc_seq_if
//
// Purpose:
//   Bundles the command/result handshake of desloc_seq together with the
//   control/feedback lines of the 4-bit shift register it sequences.
//
// Signals:
//   start     command strobe (accepted only while the sequencer is idle)
//   op_data   4-bit operand
//   op_mode   shift mode: 00 hold, 01 logical right, 10 logical left,
//             11 arithmetic right
//   op_count  number of shift steps, 0..7
//   sr_q      shift register output, fed back to the sequencer
//   sr_enable shift register enable
//   sr_select shift register function select
//   sr_data   shift register parallel data
//   busy      command in progress
//   done      one-cycle completion pulse, result valid while high
//   result    final register value of the last completed command
//
// Modports:
//   master  command issuer / shift register side
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface desloc_seq_if;
    logic       start;
    logic [3:0] op_data;
    logic [1:0] op_mode;
    logic [2:0] op_count;
    logic [3:0] sr_q;
    logic       sr_enable;
    logic [1:0] sr_select;
    logic [3:0] sr_data;
    logic       busy;
    logic       done;
    logic [3:0] result;

    modport master (
        output start,
        output op_data,
        output op_mode,
        output op_count,
        output sr_q,
        input  sr_enable,
        input  sr_select,
        input  sr_data,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op_data,
        input  op_mode,
        input  op_count,
        input  sr_q,
        output sr_enable,
        output sr_select,
        output sr_data,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/desloc_seq.sv
// -----------------------------------------------------------------------------
// desloc_seq
//
// Purpose:
//   Sequencer for the 4-bit shift register. A single command (operand, mode,
//   count) is accepted in IDLE; the operand is parallel-loaded into the
//   register, the register is then stepped op_count times through its
//   feedback path, and the final register value is returned in result with a
//   one-cycle done pulse.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset, shared with the shift register
//   bus   slave modport of desloc_seq_if:
//           start/op_data/op_mode/op_count  command in
//           sr_q                            shift register feedback in
//           sr_enable/sr_select/sr_data     shift register control out
//           busy/done/result                status and result out
//
// Timing (start sampled at edge 0, N = op_count):
//   edge 0      -> LOAD, busy rises
//   edge 1      -> sr_q = operand, state SHIFT (N>0) or DONE (N=0)
//   edge N+1    -> DONE
//   edge N+2    -> IDLE, done = 1, result updated
// -----------------------------------------------------------------------------
module desloc_seq (
    input  logic         clk,
    input  logic         rst,
    desloc_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLoad  = 2'b01,
        StShift = 2'b10,
        StDone  = 2'b11
    } state_e;

    // Shift-register select encodings
    localparam logic [1:0] SelLoad = 2'b00;

    state_e     r_state;
    state_e     w_state_next;

    logic [1:0] r_mode;
    logic [3:0] r_data;
    logic [2:0] r_cnt;     // shift steps still to perform
    logic [3:0] r_result;
    logic       r_done;

    logic       w_accept;
    logic       w_sr_enable;
    logic [1:0] w_sr_select;
    logic [3:0] w_sr_data;
    logic       w_busy;

    // A command is taken only from IDLE; start while busy is dropped.
    assign w_accept = (r_state == StIdle) && bus.start;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_state_next = (r_cnt != 3'd0) ? StShift : StDone;
            end
            StShift: begin
                // The step happening this cycle is the last one.
                if (r_cnt == 3'd1) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (Moore, decoded from state)
    // -------------------------------------------------------------------------
    always_comb begin
        w_sr_enable = 1'b0;
        w_sr_select = 2'b00;
        w_sr_data   = 4'b0000;
        w_busy      = 1'b1;
        case (r_state)
            StIdle: begin
                w_busy = 1'b0;
            end
            StLoad: begin
                w_sr_enable = 1'b1;
                w_sr_select = SelLoad;
                w_sr_data   = r_data;
            end
            StShift: begin
                // Feed the register its own output; the select picks the step.
                // Mode 00 reloads the same value, so hold steps still count.
                w_sr_enable = 1'b1;
                w_sr_select = r_mode;
                w_sr_data   = bus.sr_q;
            end
            StDone: begin
                w_sr_enable = 1'b0;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command capture, step counter, result and done pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= 2'b00;
            r_data   <= 4'b0000;
            r_cnt    <= 3'd0;
            r_result <= 4'b0000;
            r_done   <= 1'b0;
        end else begin
            // done is high for exactly the IDLE cycle that follows DONE.
            r_done <= (r_state == StDone);

            if (w_accept) begin
                r_mode <= bus.op_mode;
                r_data <= bus.op_data;
                r_cnt  <= bus.op_count;
            end

            if (r_state == StShift) begin
                r_cnt <= r_cnt - 3'd1;
            end

            // In DONE the register already holds the value after all steps.
            if (r_state == StDone) begin
                r_result <= bus.sr_q;
            end
        end
    end

    assign bus.sr_enable = w_sr_enable;
    assign bus.sr_select = w_sr_select;
    assign bus.sr_data   = w_sr_data;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;

endmodule
